bcd_updown_cnt: RTL and testbench

- Parametrised two-digit BCD modulo-MOD counter with up/down count, parallel load, and carry-out/borrow-out.
- Next generation of the 0-59 seconds/minutes counter used in the clock chapter.
- Instances chain via CA/BO into the next stage's CEN/DEC, e.g. sec(60) -> min(60) -> hour(24).
- Supports manual set (INC/DEC) and direct time load.

---
 rtl/cnt_pkg.sv | 20 ++
 rtl/bcd_digit.sv | 48 ++++
 rtl/bcd_updown_cnt.sv | 122 ++++++++++++
 tb/tb_bcd_updown_cnt.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared BCD types, digit limits and the per-cycle operation encoding
// used by the up/down BCD counter and its digit slice.
package cnt_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_UP,
        OP_DN,
        OP_LD
    } cnt_op_t;

    function automatic logic bcd_valid(input bcd_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit (0..9) with load, forced wrap value and
// natural up/down stepping; at_max/at_zero feed the neighbouring digit.
module bcd_digit
    import cnt_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic up,
    input  logic dn,
    input  logic load,
    input  logic wrap,
    input  bcd_t load_val,
    input  bcd_t wrap_val,
    output bcd_t digit,
    output logic at_max,
    output logic at_zero
);

    bcd_t digit_reg;
    bcd_t digit_next;

    assign at_max  = (digit_reg == BCD_MAX);
    assign at_zero = (digit_reg == 4'd0);
    assign digit   = digit_reg;

    // wrap carries the modulus-dependent value chosen by the owner of the count
    always_comb begin
        digit_next = digit_reg;
        if (load) begin
            digit_next = load_val;
        end else if (wrap) begin
            digit_next = wrap_val;
        end else if (up) begin
            digit_next = at_max ? 4'd0 : digit_reg + 4'd1;
        end else if (dn) begin
            digit_next = at_zero ? BCD_MAX : digit_reg - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            digit_reg <= 4'd0;
        end else begin
            digit_reg <= digit_next;
        end
    end

endmodule

// File: rtl/bcd_updown_cnt.sv
// Two-digit BCD modulo-MOD up/down counter with parallel load and CA/BO chaining.
// Define BCD_CNT_SAT_EN to make manual INC/DEC saturate instead of wrapping.
module bcd_updown_cnt
    import cnt_pkg::*;
#(
    parameter int MOD    = 60,
    parameter int TENS_W = 3
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              CEN,
    input  logic              INC,
    input  logic              DEC,
    input  logic              LOAD,
    input  logic [TENS_W-1:0] LD_TENS,
    input  logic [3:0]        LD_ONES,
    output logic [TENS_W-1:0] tens_place,
    output logic [3:0]        ones_place,
    output logic              CA,
    output logic              BO
);

    localparam logic [TENS_W-1:0] TENS_TOP = TENS_W'((MOD - 1) / 10);
    localparam bcd_t              ONES_TOP = 4'((MOD - 1) % 10);

    logic [TENS_W-1:0] tens_reg;
    logic [TENS_W-1:0] tens_next;
    bcd_t              ones;
    logic              ones_max;
    logic              ones_zero;
    logic              up;
    logic              at_top;
    logic              at_bot;
    logic              ld_ok;
    logic              sat_up;
    logic              sat_dn;
    cnt_op_t           op;

    assign up     = CEN | INC;
    assign at_top = (tens_reg == TENS_TOP) && (ones == ONES_TOP);
    assign at_bot = (tens_reg == '0) && ones_zero;

    // digit-wise range check of the load value against MOD-1
    assign ld_ok = bcd_valid(LD_ONES) &&
                   ((LD_TENS < TENS_TOP) || ((LD_TENS == TENS_TOP) && (LD_ONES <= ONES_TOP)));

`ifdef BCD_CNT_SAT_EN
    // the timebase still wraps; only a purely manual step is clamped
    assign sat_up = INC & ~CEN & at_top;
    assign sat_dn = at_bot;
`else
    assign sat_up = 1'b0;
    assign sat_dn = 1'b0;
`endif

    always_comb begin
        op = OP_HOLD;
        if (LOAD) begin
            op = OP_LD;
        end else if (up && !DEC && !sat_up) begin
            op = OP_UP;
        end else if (DEC && !up && !sat_dn) begin
            op = OP_DN;
        end
    end

    bcd_digit u_ones (
        .clk      (clk),
        .n_rst    (n_rst),
        .up       (op == OP_UP),
        .dn       (op == OP_DN),
        .load     (op == OP_LD),
        .wrap     (((op == OP_UP) && at_top) || ((op == OP_DN) && at_bot)),
        .load_val (ld_ok ? LD_ONES : 4'd0),
        .wrap_val ((op == OP_DN) ? ONES_TOP : 4'd0),
        .digit    (ones),
        .at_max   (ones_max),
        .at_zero  (ones_zero)
    );

    always_comb begin
        tens_next = tens_reg;
        case (op)
            OP_LD: tens_next = ld_ok ? LD_TENS : '0;
            OP_UP: begin
                if (at_top) begin
                    tens_next = '0;
                end else if (ones_max) begin
                    tens_next = tens_reg + TENS_W'(1);
                end
            end
            OP_DN: begin
                if (at_bot) begin
                    tens_next = TENS_TOP;
                end else if (ones_zero) begin
                    tens_next = tens_reg - TENS_W'(1);
                end
            end
            default: tens_next = tens_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            tens_reg <= '0;
        end else begin
            tens_reg <= tens_next;
        end
    end

    assign tens_place = tens_reg;
    assign ones_place = ones;

    // INC deliberately does not qualify CA so manual setting never ripples onward
    assign CA = n_rst & CEN & ~DEC & ~LOAD & at_top;
`ifdef BCD_CNT_SAT_EN
    assign BO = 1'b0;
`else
    assign BO = n_rst & DEC & ~CEN & ~INC & ~LOAD & at_bot;
`endif

endmodule

// File: tb/tb_bcd_updown_cnt.sv
// Self-checking bench: a MOD=60 and a MOD=24 counter driven in lockstep,
// checked against table vectors, hand sequences and an arithmetic model.
module tb_bcd_updown_cnt;

`ifdef BCD_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       n_rst;
    logic       CEN;
    logic       INC;
    logic       DEC;
    logic       LOAD;
    logic [2:0] LD_TENS;
    logic [3:0] LD_ONES;
    logic [2:0] tens_a;
    logic [3:0] ones_a;
    logic       ca_a;
    logic       bo_a;
    logic [2:0] tens_b;
    logic [3:0] ones_b;
    logic       ca_b;
    logic       bo_b;

    int n_checks = 0;
    int n_fail   = 0;
    int v60      = 0;
    int v24      = 0;

    typedef struct {
        bit cen;
        bit inc;
        bit dec;
        bit load;
        int ldt;
        int ldo;
        int exp_v;
        bit exp_ca;
        bit exp_bo;
    } vec_t;

    vec_t tbl[21];

    bcd_updown_cnt #(.MOD(60), .TENS_W(3)) dut_a (
        .clk(clk), .n_rst(n_rst), .CEN(CEN), .INC(INC), .DEC(DEC), .LOAD(LOAD),
        .LD_TENS(LD_TENS), .LD_ONES(LD_ONES),
        .tens_place(tens_a), .ones_place(ones_a), .CA(ca_a), .BO(bo_a)
    );

    bcd_updown_cnt #(.MOD(24), .TENS_W(3)) dut_b (
        .clk(clk), .n_rst(n_rst), .CEN(CEN), .INC(INC), .DEC(DEC), .LOAD(LOAD),
        .LD_TENS(LD_TENS), .LD_ONES(LD_ONES),
        .tens_place(tens_b), .ones_place(ones_b), .CA(ca_b), .BO(bo_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Next value of a mod-m counter straight from the counting rules.
    function automatic int model_step(input int m, input int v, input bit rn, input bit cen,
                                      input bit inc, input bit dec, input bit load,
                                      input int ldt, input int ldo,
                                      output bit ca, output bit bo);
        int nv;
        ca = 1'b0;
        bo = 1'b0;
        nv = v;
        if (!rn) return 0;
        if (load) begin
            nv = (ldo <= 9 && ldt * 10 + ldo < m) ? ldt * 10 + ldo : 0;
        end else if ((cen || inc) && dec) begin
            nv = v;
        end else if (cen || inc) begin
            if (v == m - 1) begin
                ca = cen;
                nv = (SAT && !cen) ? v : 0;
            end else begin
                nv = v + 1;
            end
        end else if (dec) begin
            if (v == 0) begin
                bo = !SAT;
                nv = SAT ? 0 : m - 1;
            end else begin
                nv = v - 1;
            end
        end
        return nv;
    endfunction

    // One clock: drive at posedge+1, check CA/BO at negedge, values at next posedge+1.
    task automatic cycle(input bit rn, input bit c, input bit i, input bit d, input bit l,
                         input int lt, input int lo,
                         output logic [1:0] ca_s, output logic [1:0] bo_s);
        bit e_ca_a, e_bo_a, e_ca_b, e_bo_b;
        int n_a, n_b;
        n_rst   = rn;
        CEN     = c;
        INC     = i;
        DEC     = d;
        LOAD    = l;
        LD_TENS = 3'(lt);
        LD_ONES = 4'(lo);
        n_a = model_step(60, v60, rn, c, i, d, l, lt & 7, lo & 15, e_ca_a, e_bo_a);
        n_b = model_step(24, v24, rn, c, i, d, l, lt & 7, lo & 15, e_ca_b, e_bo_b);
        @(negedge clk);
        ca_s = {ca_a, ca_b};
        bo_s = {bo_a, bo_b};
        check("ca60", int'(ca_a), int'(e_ca_a));
        check("bo60", int'(bo_a), int'(e_bo_a));
        check("ca24", int'(ca_b), int'(e_ca_b));
        check("bo24", int'(bo_b), int'(e_bo_b));
        @(posedge clk);
        #1;
        v60 = n_a;
        v24 = n_b;
        check("tens60", int'(tens_a), v60 / 10);
        check("ones60", int'(ones_a), v60 % 10);
        check("tens24", int'(tens_b), v24 / 10);
        check("ones24", int'(ones_b), v24 % 10);
        $display("txn rst_n=%0d cen=%0d inc=%0d dec=%0d ld=%0d(%0d,%0d) -> m60=%0d%0d ca=%0d bo=%0d | m24=%0d%0d ca=%0d bo=%0d",
                 rn, c, i, d, l, lt, lo, tens_a, ones_a, ca_s[1], bo_s[1],
                 tens_b, ones_b, ca_s[0], bo_s[0]);
    endtask

    initial begin
        logic [1:0] ca;
        logic [1:0] bo;

        tbl[0]  = '{0, 0, 0, 1, 5, 9,  59, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0,  0,  1, 0};
        tbl[2]  = '{0, 0, 1, 0, 0, 0,  SAT ? 0 : 59, 0, !SAT};
        tbl[3]  = '{0, 0, 0, 1, 5, 9,  59, 0, 0};
        tbl[4]  = '{0, 0, 1, 0, 0, 0,  58, 0, 0};
        tbl[5]  = '{0, 0, 0, 1, 5, 9,  59, 0, 0};
        tbl[6]  = '{0, 1, 0, 0, 0, 0,  SAT ? 59 : 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 1, 5, 9,  59, 0, 0};
        tbl[8]  = '{1, 0, 1, 0, 0, 0,  59, 0, 0};
        tbl[9]  = '{0, 0, 0, 1, 6, 0,  0,  0, 0};
        tbl[10] = '{0, 0, 0, 1, 1, 12, 0,  0, 0};
        tbl[11] = '{0, 0, 0, 1, 3, 7,  37, 0, 0};
        tbl[12] = '{1, 1, 0, 0, 0, 0,  38, 0, 0};
        tbl[13] = '{0, 0, 0, 1, 1, 9,  19, 0, 0};
        tbl[14] = '{0, 1, 0, 0, 0, 0,  20, 0, 0};
        tbl[15] = '{0, 0, 1, 0, 0, 0,  19, 0, 0};
        tbl[16] = '{1, 1, 1, 1, 5, 9,  59, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 0,  59, 0, 0};
        tbl[18] = '{1, 1, 0, 0, 0, 0,  0,  1, 0};
        tbl[19] = '{0, 0, 0, 1, 0, 0,  0,  0, 0};
        tbl[20] = '{0, 1, 1, 0, 0, 0,  0,  0, 0};

        n_rst = 1'b0; CEN = 1'b0; INC = 1'b0; DEC = 1'b0; LOAD = 1'b0;
        LD_TENS = '0; LD_ONES = '0;
        @(posedge clk);
        #1;

        // reset with activity on the inputs: CA/BO must stay low
        cycle(0, 1, 0, 1, 0, 0, 0, ca, bo);
        check("rst_ca", int'(ca[1]), 0);
        check("rst_bo", int'(bo[1]), 0);

        // free-running count over a full period
        for (int k = 0; k < 60; k++) begin
            cycle(1, 1, 0, 0, 0, 0, 0, ca, bo);
            check("count_ca60", int'(ca[1]), (k == 59) ? 1 : 0);
        end
        check("count_wrap", int'(tens_a) * 10 + int'(ones_a), 0);

        for (int k = 0; k < 21; k++) begin
            cycle(1, tbl[k].cen, tbl[k].inc, tbl[k].dec, tbl[k].load,
                  tbl[k].ldt, tbl[k].ldo, ca, bo);
            check("tbl_ca", int'(ca[1]), int'(tbl[k].exp_ca));
            check("tbl_bo", int'(bo[1]), int'(tbl[k].exp_bo));
            check("tbl_val", int'(tens_a) * 10 + int'(ones_a), tbl[k].exp_v);
        end

        // modulus-24 wrap and load validation
        cycle(1, 0, 0, 0, 1, 2, 3, ca, bo);
        check("m24_load23", int'(tens_b) * 10 + int'(ones_b), 23);
        cycle(1, 1, 0, 0, 0, 0, 0, ca, bo);
        check("m24_ca", int'(ca[0]), 1);
        check("m24_wrap", int'(tens_b) * 10 + int'(ones_b), 0);
        cycle(1, 0, 0, 0, 1, 2, 4, ca, bo);
        check("m24_load24", int'(tens_b) * 10 + int'(ones_b), 0);
        cycle(1, 0, 0, 0, 1, 1, 12, ca, bo);
        check("m24_load1_12", int'(tens_b) * 10 + int'(ones_b), 0);

        // held manual increment across the top
        cycle(1, 0, 0, 0, 1, 5, 9, ca, bo);
        for (int k = 0; k < 3; k++) cycle(1, 0, 1, 0, 0, 0, 0, ca, bo);
        check("inc_hold", int'(tens_a) * 10 + int'(ones_a), SAT ? 59 : 2);

        // manual decrement from zero
        cycle(1, 0, 0, 0, 1, 0, 0, ca, bo);
        cycle(1, 0, 0, 1, 0, 0, 0, ca, bo);
        check("dec0_bo", int'(bo[1]), SAT ? 0 : 1);
        check("dec0_val", int'(tens_a) * 10 + int'(ones_a), SAT ? 0 : 59);

        // reset in the middle of counting
        cycle(1, 0, 0, 0, 1, 3, 6, ca, bo);
        cycle(1, 1, 0, 0, 0, 0, 0, ca, bo);
        check("mid_37", int'(tens_a) * 10 + int'(ones_a), 37);
        cycle(0, 1, 0, 0, 0, 0, 0, ca, bo);
        check("mid_rst_ca", int'(ca[1]), 0);
        check("mid_rst_val", int'(tens_a) * 10 + int'(ones_a), 0);
        cycle(1, 1, 0, 0, 0, 0, 0, ca, bo);
        check("mid_resume", int'(tens_a) * 10 + int'(ones_a), 1);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 31) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 11) == 0,
                  int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)),
                  ca, bo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
